// File: rtl/lcd_pkg.sv
// Shared constants, state types and helpers for the HD44780 4-bit LCD writer.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h28;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_DDRAM0   = 8'h80;

  localparam logic [13:0] DLY_PWR_US   = 14'd15000;
  localparam logic [13:0] DLY_INIT0_US = 14'd4100;
  localparam logic [13:0] DLY_INIT1_US = 14'd100;
  localparam logic [13:0] DLY_CMD_US   = 14'd40;
  localparam logic [13:0] DLY_CLEAR_US = 14'd1640;
  localparam logic [13:0] DLY_GAP_US   = 14'd1;

  typedef enum logic [3:0] {
    StPwrWait, StInit0, StInit1, StInit2, StInit3,
    StCfg0, StCfg1, StCfg2, StCfg3, StIdle, StAddr, StChar
  } state_t;

  typedef enum logic [2:0] {TxIdle, TxSetup, TxEHi, TxHold, TxGap, TxWait} tx_state_t;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

endpackage

// File: rtl/lcd_q_writer_if.sv
// 4-bit HD44780 character LCD write bus.
interface lcd_q_writer_if;
  logic [3:0] lcd_d;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;

  modport master (output lcd_d, lcd_e, lcd_rs, lcd_rw);
  modport slave  (input  lcd_d, lcd_e, lcd_rs, lcd_rw);
endinterface

// File: rtl/lcd_byte_tx.sv
// E-pulse sequencer: sends one nibble or a full byte (high, 1 us gap, low) then waits wait_us.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int unsigned CYC_PER_US = 50,
  parameter int unsigned E_CYC      = 12
) (
  input  logic        clk,
  input  logic        rs,
  input  logic        start,
  input  logic [7:0]  tx_byte,
  input  logic        rs_bit,
  input  logic        nibble_only,
  input  logic [13:0] wait_us,
  output logic        done,
  output logic [3:0]  lcd_d,
  output logic        lcd_e,
  output logic        lcd_rs
);

  localparam int unsigned MaxCyc = 32'(DLY_PWR_US) * CYC_PER_US;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam logic [CntW-1:0] ECnt   = CntW'(E_CYC - 1);
  localparam logic [CntW-1:0] GapCnt = CntW'(32'(DLY_GAP_US) * CYC_PER_US - 1);

  tx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic [3:0]      lo_q, lo_d;
  logic            second_q, second_d;
  logic [3:0]      d_q, d_d;
  logic            e_q, e_d;
  logic            rsb_q, rsb_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    lo_d     = lo_q;
    second_d = second_q;
    d_d      = d_q;
    e_d      = e_q;
    rsb_d    = rsb_q;
    done     = 1'b0;
    case (state_q)
      TxIdle: begin
        if (start) begin
          // A lone nibble travels in the low half of tx_byte.
          d_d      = nibble_only ? tx_byte[3:0] : tx_byte[7:4];
          lo_d     = tx_byte[3:0];
          second_d = !nibble_only;
          rsb_d    = rs_bit;
          wait_d   = CntW'(32'(wait_us) * CYC_PER_US - 1);
          state_d  = TxSetup;
        end
      end
      TxSetup: begin
        e_d     = 1'b1;
        cnt_d   = ECnt;
        state_d = TxEHi;
      end
      TxEHi: begin
        if (cnt_q == '0) begin
          e_d     = 1'b0;
          state_d = TxHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      TxHold: begin
        if (second_q) begin
          cnt_d   = GapCnt;
          state_d = TxGap;
        end else begin
          cnt_d   = wait_q;
          state_d = TxWait;
        end
      end
      TxGap: begin
        if (cnt_q == '0) begin
          d_d      = lo_q;
          second_d = 1'b0;
          state_d  = TxSetup;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      TxWait: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = TxIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q  <= TxIdle;
      cnt_q    <= '0;
      wait_q   <= '0;
      lo_q     <= '0;
      second_q <= 1'b0;
      d_q      <= '0;
      e_q      <= 1'b0;
      rsb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      lo_q     <= lo_d;
      second_q <= second_d;
      d_q      <= d_d;
      e_q      <= e_d;
      rsb_q    <= rsb_d;
    end
  end

  assign lcd_d  = d_q;
  assign lcd_e  = e_q;
  assign lcd_rs = rsb_q;

endmodule

// File: rtl/lcd_q_writer.sv
// Renders q on the 16x2 LCD as "Q=ddd" (or "Q=hh " with LCD_Q_WRITER_HEX_EN), rewriting on change.
module lcd_q_writer
  import lcd_pkg::*;
#(
  parameter int unsigned CYC_PER_US = 50,
  parameter int unsigned E_CYC      = 12
) (
  input  logic           clk,
  input  logic           rs,
  input  logic [7:0]     q,
  lcd_q_writer_if.master lcd,
  output logic           busy
);

  localparam int unsigned PwrCycles = 32'(DLY_PWR_US) * CYC_PER_US;
  localparam int unsigned PwrW      = $clog2(PwrCycles + 1);
  localparam logic [PwrW-1:0] PwrLoad = PwrW'(PwrCycles - 1);

  state_t          state_q, state_d;
  logic [PwrW-1:0] pwr_q;
  logic [7:0]      snap_q, last_q;
  logic [2:0]      idx_q;
  logic            issued_q;

  logic        start, rs_bit, nibble_only, done;
  logic [7:0]  tx_byte, chr;
  logic [13:0] wait_us;
  logic [7:0]  dig2, dig3, dig4;

`ifdef LCD_Q_WRITER_HEX_EN
  assign dig2 = digit_to_ascii(snap_q[7:4]);
  assign dig3 = digit_to_ascii(snap_q[3:0]);
  assign dig4 = 8'h20;
`else
  assign dig2 = digit_to_ascii(4'(snap_q / 8'd100));
  assign dig3 = digit_to_ascii(4'((snap_q / 8'd10) % 8'd10));
  assign dig4 = digit_to_ascii(4'(snap_q % 8'd10));
`endif

  always_comb begin
    case (idx_q)
      3'd0:    chr = 8'h51;
      3'd1:    chr = 8'h3D;
      3'd2:    chr = dig2;
      3'd3:    chr = dig3;
      default: chr = dig4;
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) state_q <= StPwrWait;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StPwrWait: if (pwr_q == '0) state_d = StInit0;
      StInit0:   if (done) state_d = StInit1;
      StInit1:   if (done) state_d = StInit2;
      StInit2:   if (done) state_d = StInit3;
      StInit3:   if (done) state_d = StCfg0;
      StCfg0:    if (done) state_d = StCfg1;
      StCfg1:    if (done) state_d = StCfg2;
      StCfg2:    if (done) state_d = StCfg3;
      StCfg3:    if (done) state_d = StAddr;
      StIdle:    if (q != last_q) state_d = StAddr;
      StAddr:    if (done) state_d = StChar;
      StChar:    if (done && idx_q == 3'd4) state_d = StIdle;
      default:   state_d = StPwrWait;
    endcase
  end

  // Each state issues exactly one transfer; IDLE launches the address command itself so the
  // first E-pulse follows the snapshot by only the setup cycle.
  always_comb begin
    start       = !issued_q;
    tx_byte     = LCD_DDRAM0;
    rs_bit      = 1'b0;
    nibble_only = 1'b0;
    wait_us     = DLY_CMD_US;
    busy        = (state_q != StIdle);
    case (state_q)
      StPwrWait: start = 1'b0;
      StInit0: begin
        tx_byte     = 8'h03;
        nibble_only = 1'b1;
        wait_us     = DLY_INIT0_US;
      end
      StInit1: begin
        tx_byte     = 8'h03;
        nibble_only = 1'b1;
        wait_us     = DLY_INIT1_US;
      end
      StInit2: begin
        tx_byte     = 8'h03;
        nibble_only = 1'b1;
      end
      StInit3: begin
        tx_byte     = 8'h02;
        nibble_only = 1'b1;
      end
      StCfg0:  tx_byte = LCD_FUNC_SET;
      StCfg1:  tx_byte = LCD_ENTRY;
      StCfg2:  tx_byte = LCD_DISP_ON;
      StCfg3: begin
        tx_byte = LCD_CLEAR;
        wait_us = DLY_CLEAR_US;
      end
      StIdle:  start = (q != last_q);
      StChar: begin
        tx_byte = chr;
        rs_bit  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      pwr_q    <= PwrLoad;
      snap_q   <= 8'h00;
      last_q   <= 8'h00;
      idx_q    <= 3'd0;
      issued_q <= 1'b0;
    end else begin
      if (state_q == StPwrWait && pwr_q != '0) pwr_q <= pwr_q - PwrW'(1);
      if (done)       issued_q <= 1'b0;
      else if (start) issued_q <= 1'b1;
      if ((state_q == StCfg3 && done) || (state_q == StIdle && q != last_q)) begin
        snap_q <= q;
        last_q <= q;
      end
      if (state_q == StAddr)             idx_q <= 3'd0;
      else if (state_q == StChar && done) idx_q <= idx_q + 3'd1;
    end
  end

  lcd_byte_tx #(
    .CYC_PER_US (CYC_PER_US),
    .E_CYC      (E_CYC)
  ) u_tx (
    .clk         (clk),
    .rs          (rs),
    .start       (start),
    .tx_byte     (tx_byte),
    .rs_bit      (rs_bit),
    .nibble_only (nibble_only),
    .wait_us     (wait_us),
    .done        (done),
    .lcd_d       (lcd.lcd_d),
    .lcd_e       (lcd.lcd_e),
    .lcd_rs      (lcd.lcd_rs)
  );

  assign lcd.lcd_rw = 1'b0;

endmodule

// File: doc/lcd_q_writer.md
# lcd_q_writer

Display end of the button path: takes the 8-bit count `q` produced by the button/debounce counter and renders it on the Spartan-3E 16x2 character LCD over the 4-bit HD44780 interface. After power-up it runs the HD44780 4-bit initialisation and configuration sequence itself. Whenever `q` differs from the value last written, it rewrites the five characters at line 1, column 0.

## Interface
- `CYC_PER_US`, 50: clock cycles per microsecond (50 MHz board clock). All LCD delays derive from it.
- `E_CYC`, 12: `lcd_e` high time in cycles, at least 1.
- `clk`  in  1: single clock; every register is on its rising edge.
- `rs`  in  1: reset, asynchronous, active-low.
- `q`  in  8: value to display, sampled every cycle.
- `lcd_d`  out  4: LCD data nibble (board SF_D[11:8]).
- `lcd_e`  out  1: LCD enable strobe.
- `lcd_rs`  out  1: LCD register select; 0 = command, 1 = data.
- `lcd_rw`  out  1: tied 0; the block is write-only and never reads busy.
- `busy`  out  1: high during init, configuration and any screen update.

## Operation
- Reset values: `lcd_d`=0, `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `busy`=1, `last`=8'h00. The FSM enters PWR_WAIT.
- Main FSM states: PWR_WAIT, INIT0..INIT3, CFG0..CFG3, IDLE, ADDR, CHAR.
- PWR_WAIT: hold for 15000 µs.
- INIT0..INIT3: single-nibble writes with `lcd_rs`=0.
  - 0x3, then wait 4100 µs.
  - 0x3, then wait 100 µs.
  - 0x3, then wait 40 µs.
  - 0x2, then wait 40 µs.
- CFG0..CFG3: full-byte commands in this order.
  - 0x28, function set.
  - 0x06, entry mode.
  - 0x0C, display on, no cursor.
  - 0x01, clear, followed by a 1640 µs wait.
- After CFG3, go to ADDR with `snap`=`q`. The first update always occurs, even when `q`=0.
- IDLE: `busy`=0.
  - If `q`!=`last`: `snap`<=`q`, `last`<=`q`, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR: command 0x80 (DDRAM address 0), then go to CHAR.
- CHAR: five data bytes (`lcd_rs`=1) derived from `snap`, then back to IDLE.
  - Default text: 'Q','=', hundreds, tens, units.
  - Digits are ASCII 0x30+d. Leading zeros are shown.
- Byte write: high nibble E-pulse, 1 µs gap, low nibble E-pulse, 40 µs wait. Clear uses a 1640 µs wait instead.
- `q` changing during an update does not disturb the update. The newest value is picked up in IDLE, and intermediate values are dropped.
- Reset asserted mid-sequence: outputs go to their reset values immediately, and the full init restarts from PWR_WAIT.

## Timing
- E-pulse protocol:
  - `lcd_d`/`lcd_rs` are driven 1 cycle before `lcd_e` rises.
  - `lcd_e` stays high exactly `E_CYC` cycles.
  - Data is held 1 cycle after `lcd_e` falls.
- A delay of N µs is N*`CYC_PER_US` cycles counted after the hold cycle.
- The delay counter is wide enough for 15000*`CYC_PER_US`.
- IDLE to first `lcd_e` of the address command: 2 cycles (snapshot, then setup).
- `busy` rises in the cycle after the snapshot. It falls on the cycle the FSM re-enters IDLE.
- Full update with default parameters: 6 bytes of about 42 µs each, so about 252 µs.
- BCD conversion of `snap` is combinational, or done before the ADDR command finishes. It adds no latency beyond the byte sequence.

## Configuration
- `LCD_Q_WRITER_HEX_EN`
  - Defined: CHAR sends 'Q','=', hex high digit, hex low digit, ' ' (space). Hex digits are uppercase ASCII (0x30–0x39, 0x41–0x46). The BCD logic is compiled out.
  - Undefined: decimal text as in Operation.
- The character count stays 5 in both builds.

## Structure
- Shared package `lcd_pkg`:
  - Command constants: `LCD_FUNC_SET`=0x28, `LCD_ENTRY`=0x06, `LCD_DISP_ON`=0x0C, `LCD_CLEAR`=0x01, `LCD_DDRAM0`=0x80.
  - Delay constants in µs: 15000, 4100, 100, 40, 1640, 1.
  - Main FSM state typedef.
  - Function digit-to-ASCII.
- Sub-module `lcd_byte_tx`:
  - Inputs: `start`, `byte`, `rs_bit`, `nibble_only`, `wait_us`.
  - Outputs: `done` pulse, plus the owned `lcd_d`/`lcd_e`/`lcd_rs`.
  - Contains the E-pulse sequencer and delay counter.
  - The main FSM only sequences commands and characters.

## Test plan
Benches use `CYC_PER_US`=1 and `E_CYC`=2.
- Reset release:
  - `lcd_e` pulses are seen in order: nibbles 3,3,3,2, then bytes 28,06,0C,01.
  - Gaps are ≥15000, 4100, 100, 40 cycles, and 1640 after the clear.
  - `busy` stays 1 throughout.
- First update after init with `q`=0: bytes 80,51,3D,30,30,30; then `busy`=0.
- In IDLE, `q`=8'd255: `busy` rises and the bytes are 80,51,3D,32,35,35.
- `q` stepping 7→8→9 during an update of 7: only the update for 9 follows (80,51,3D,30,30,39).
- Reset pulse mid-CHAR: all outputs return to reset values at once, and the init sequence repeats from PWR_WAIT.
- `LCD_Q_WRITER_HEX_EN` defined, `q`=8'hA5: bytes 80,51,3D,41,35,20.
